// File: rtl/edm_pio_pkg.sv
// Shared definitions for masters that talk to the EDM_Standard edge-capturing PIO.
package edm_pio_pkg;

  // PIO slave register map
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam logic [1:0] PIO_MASK_ADDR = 2'd2;
  localparam logic [1:0] PIO_EDGE_ADDR = 2'd3;

  // Largest slave read latency the read timer counter is sized for
  localparam int unsigned MAX_READ_LATENCY = 4;

  // Interrupt service sequence
  typedef enum logic [2:0] {
    INIT_MASK = 3'd0,
    IDLE      = 3'd1,
    RD_EDGE   = 3'd2,
    RD_LEVEL  = 3'd3,
    CLR       = 3'd4,
    EMIT      = 3'd5
  } svc_state_e;

endpackage

// File: rtl/avalon_read_timer.sv
// Counts cycles of an Avalon read and flags the cycle on which readdata is valid.
// READ_LATENCY must lie in 1..MAX_READ_LATENCY; the counter is sized for that range.
module avalon_read_timer
  import edm_pio_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic run_i,
  output logic sample_o
);

  localparam int unsigned CW = $clog2(MAX_READ_LATENCY + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear has priority so the next read always starts from zero
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (run_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Latency counter register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The address was sampled on the first read cycle, so data lands READ_LATENCY cycles later
  assign sample_o = run_i && (count_q == CW'(READ_LATENCY));

endmodule

// File: rtl/button_irq_service.sv
// Avalon-MM master that services the push-button PIO interrupt without a CPU:
// programs the IRQ mask, reads edge and level registers, clears the edges and
// hands the result downstream as a valid/ready event.
module button_irq_service
  import edm_pio_pkg::*;
#(
  parameter int unsigned      WIDTH        = 3,
  parameter logic [WIDTH-1:0] MASK         = {WIDTH{1'b1}},
  parameter int unsigned      READ_LATENCY = 1,
  parameter logic [1:0]       DATA_ADDR    = PIO_DATA_ADDR,
  parameter logic [1:0]       MASK_ADDR    = PIO_MASK_ADDR,
  parameter logic [1:0]       EDGE_ADDR    = PIO_EDGE_ADDR
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             irq,
  output logic [1:0]       address,
  output logic             chipselect,
  output logic             write_n,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [WIDTH-1:0] event_edges,
  output logic [WIDTH-1:0] event_level,
  output logic [15:0]      event_count
);

  svc_state_e       state_q;
  logic [1:0]       address_q;
  logic             chipselect_q;
  logic             write_n_q;
  logic [31:0]      writedata_q;
  logic             event_valid_q;
  logic [WIDTH-1:0] edges_q;
  logic [WIDTH-1:0] level_q;
  logic [15:0]      count_q;

  logic             sample;
  logic             timer_clear;
  logic             timer_run;
  logic [WIDTH-1:0] rd_bits;
  logic             unused_rd_upper;

  // Only the serviced pins matter; the slave may return anything above them
  assign rd_bits         = readdata[WIDTH-1:0];
  assign unused_rd_upper = ^readdata[31:WIDTH];

  // Counter restarts in IDLE and after each capture, so both read states begin at zero
  assign timer_run   = (state_q == RD_EDGE) || (state_q == RD_LEVEL);
  assign timer_clear = (state_q == IDLE) || sample;

  avalon_read_timer #(
    .READ_LATENCY(READ_LATENCY)
  ) u_read_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (timer_clear),
    .run_i   (timer_run),
    .sample_o(sample)
  );

  // Service FSM; bus and event outputs are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= INIT_MASK;
      address_q     <= '0;
      chipselect_q  <= 1'b0;
      write_n_q     <= 1'b1;
      writedata_q   <= '0;
      event_valid_q <= 1'b0;
      edges_q       <= '0;
      level_q       <= '0;
      count_q       <= '0;
    end else begin
      unique case (state_q)
        INIT_MASK: begin
          // Single write cycle programming the slave's IRQ mask
          chipselect_q <= 1'b1;
          write_n_q    <= 1'b0;
          address_q    <= MASK_ADDR;
          writedata_q  <= 32'(MASK);
          state_q      <= IDLE;
        end
        IDLE: begin
          chipselect_q <= 1'b0;
          write_n_q    <= 1'b1;
          if (irq) begin
            chipselect_q <= 1'b1;
            address_q    <= EDGE_ADDR;
            state_q      <= RD_EDGE;
          end
        end
        RD_EDGE: begin
          if (sample) begin
            edges_q <= rd_bits;
            if (rd_bits == '0) begin
              // Spurious interrupt: nothing to clear and nothing to report
              chipselect_q <= 1'b0;
              state_q      <= IDLE;
            end else begin
              address_q <= DATA_ADDR;
              state_q   <= RD_LEVEL;
            end
          end
        end
        RD_LEVEL: begin
          if (sample) begin
            level_q     <= rd_bits;
            write_n_q   <= 1'b0;
            address_q   <= EDGE_ADDR;
            writedata_q <= '1;
            state_q     <= CLR;
          end
        end
        CLR: begin
          chipselect_q  <= 1'b0;
          write_n_q     <= 1'b1;
          event_valid_q <= 1'b1;
          state_q       <= EMIT;
        end
        EMIT: begin
          if (event_ready) begin
            event_valid_q <= 1'b0;
            count_q       <= count_q + 16'd1;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q <= INIT_MASK;
        end
      endcase
    end
  end

  assign address     = address_q;
  assign chipselect  = chipselect_q;
  assign write_n     = write_n_q;
  assign writedata   = writedata_q;
  assign event_valid = event_valid_q;
  assign event_edges = edges_q;
  assign event_level = level_q;
  assign event_count = count_q;

endmodule

// File: tb/tb_button_irq_service.sv
// Bench for button_irq_service: two instances (read latency 1 and 3), each in
// front of a behavioural edge-capturing PIO slave with pins driven by the bench.
module tb_button_irq_service;

  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        irq         [N];
  logic [1:0]  address     [N];
  logic        chipselect  [N];
  logic        write_n     [N];
  logic [31:0] writedata   [N];
  logic [31:0] readdata    [N];
  logic        event_valid [N];
  logic        event_ready [N];
  logic [2:0]  event_edges [N];
  logic [2:0]  event_level [N];
  logic [15:0] event_count [N];

  // Slave model state
  logic [2:0]  pins     [N];
  logic [2:0]  pins_d   [N];
  logic [2:0]  edge_cap [N];
  logic [2:0]  mask_reg [N];
  logic        spur     [N];
  logic [31:0] pipe     [N][4];

  // Reference model state
  logic [15:0] exp_count [N];
  int vectors;
  int miscompares;

  button_irq_service #(.READ_LATENCY(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .irq(irq[0]), .address(address[0]),
    .chipselect(chipselect[0]), .write_n(write_n[0]), .writedata(writedata[0]),
    .readdata(readdata[0]), .event_valid(event_valid[0]), .event_ready(event_ready[0]),
    .event_edges(event_edges[0]), .event_level(event_level[0]), .event_count(event_count[0])
  );

  button_irq_service #(.READ_LATENCY(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .irq(irq[1]), .address(address[1]),
    .chipselect(chipselect[1]), .write_n(write_n[1]), .writedata(writedata[1]),
    .readdata(readdata[1]), .event_valid(event_valid[1]), .event_ready(event_ready[1]),
    .event_edges(event_edges[1]), .event_level(event_level[1]), .event_count(event_count[1])
  );

  // Register value returned by the slave; upper bits are junk the master must ignore
  function automatic logic [31:0] rd_value(int i);
    logic [31:0] junk;
    junk = $urandom & 32'hFFFF_FFF8;
    case (address[i])
      2'd0:    rd_value = junk | {29'd0, pins[i]};
      2'd2:    rd_value = junk | {29'd0, mask_reg[i]};
      2'd3:    rd_value = junk | {29'd0, edge_cap[i]};
      default: rd_value = junk;
    endcase
  endfunction

  // PIO slave: rising-edge capture, any write to the edge register clears it, reads pipelined
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      pins_d[i] <= pins[i];
      if (!reset_n) begin
        edge_cap[i] <= '0;
        mask_reg[i] <= '0;
      end else if (chipselect[i] && !write_n[i] && address[i] == 2'd3) begin
        edge_cap[i] <= '0;
      end else begin
        edge_cap[i] <= edge_cap[i] | (pins[i] & ~pins_d[i]);
        if (chipselect[i] && !write_n[i] && address[i] == 2'd2)
          mask_reg[i] <= writedata[i][2:0];
      end
      pipe[i][0] <= (chipselect[i] && write_n[i]) ? rd_value(i) : $urandom;
      for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
    end
  end

  assign readdata[0] = pipe[0][0];
  assign readdata[1] = pipe[1][2];
  assign irq[0] = (|(edge_cap[0] & mask_reg[0])) | spur[0];
  assign irq[1] = (|(edge_cap[1] & mask_reg[1])) | spur[1];

  // Observed bus/event view; don't-care fields are zeroed
  function automatic logic [36:0] bus_obs(int u);
    bus_obs = {event_valid[u], chipselect[u], write_n[u],
               chipselect[u] ? address[u] : 2'b00,
               (chipselect[u] && !write_n[u]) ? writedata[u] : 32'h0};
  endfunction

  // Expected bus/event view k cycles after irq is seen in IDLE, for read latency L
  function automatic logic [36:0] svc_exp(int k, int L);
    if (k >= 1 && k <= L + 1)          svc_exp = {1'b0, 1'b1, 1'b1, 2'd3, 32'h0};
    else if (k >= L + 2 && k <= 2*L+2) svc_exp = {1'b0, 1'b1, 1'b1, 2'd0, 32'h0};
    else if (k == 2*L + 3)             svc_exp = {1'b0, 1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF};
    else if (k == 2*L + 4)             svc_exp = {1'b1, 1'b0, 1'b1, 2'd0, 32'h0};
    else                               svc_exp = {1'b0, 1'b0, 1'b1, 2'd0, 32'h0};
  endfunction

  function automatic logic [58:0] rst_obs(int u);
    rst_obs = {chipselect[u], write_n[u], address[u], writedata[u], event_valid[u],
               event_edges[u], event_level[u], event_count[u]};
  endfunction

  localparam logic [58:0] RST_EXP  = {1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 3'd0, 3'd0, 16'd0};
  localparam logic [36:0] MASK_WR  = {1'b0, 1'b1, 1'b0, 2'd2, 32'h7};
  localparam logic [36:0] BUS_IDLE = {1'b0, 1'b0, 1'b1, 2'd0, 32'h0};

  // Create rising edges on bits m: drop them (no capture), then raise them
  task automatic press(int u, logic [2:0] m);
    @(negedge clk);
    pins[u] = pins[u] & ~m;
    repeat (2) @(negedge clk);
    pins[u] = pins[u] | m;
  endtask

  // Walk one service sequence from cycle k0 and check the emitted event
  task automatic expect_service(int u, int L, int k0, logic [2:0] e, logic [2:0] l);
    logic [36:0] obs;
    logic [36:0] exp;
    for (int k = k0; k <= 2*L + 4; k++) begin
      @(negedge clk);
      obs = bus_obs(u);
      exp = svc_exp(k, L);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL service_bus u%0d k=%0d got=%h expected=%h", u, k, obs, exp);
      end
    end
    vectors++;
    if ({event_edges[u], event_level[u], event_count[u]} !== {e, l, exp_count[u]}) begin
      miscompares++;
      $display("FAIL service_event u%0d got edges=%b level=%b count=%0d expected edges=%b level=%b count=%0d",
               u, event_edges[u], event_level[u], event_count[u], e, l, exp_count[u]);
    end
    $display("service u%0d L=%0d edges=%b level=%b count=%0d", u, L, event_edges[u], event_level[u], event_count[u]);
  endtask

  // Stall a while (event must stay put), then hand-shake and check the count
  task automatic accept(int u, int stall, logic [2:0] e, logic [2:0] l);
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      vectors++;
      if ({bus_obs(u), event_edges[u], event_level[u]} !== {1'b1, BUS_IDLE[35:0], e, l}) begin
        miscompares++;
        $display("FAIL hold u%0d c=%0d got=%h expected=%h", u, c,
                 {bus_obs(u), event_edges[u], event_level[u]}, {1'b1, BUS_IDLE[35:0], e, l});
      end
    end
    event_ready[u] = 1'b1;
    exp_count[u] = exp_count[u] + 16'd1;
    @(negedge clk);
    event_ready[u] = 1'b0;
    vectors++;
    if ({event_valid[u], event_count[u]} !== {1'b0, exp_count[u]}) begin
      miscompares++;
      $display("FAIL accept u%0d got valid=%b count=%0d expected valid=0 count=%0d",
               u, event_valid[u], event_count[u], exp_count[u]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < N; u++) begin
      vectors++;
      if (rst_obs(u) !== RST_EXP) begin
        miscompares++;
        $display("FAIL reset_values u%0d got=%h expected=%h", u, rst_obs(u), RST_EXP);
      end
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      for (int u = 0; u < N; u++) begin
        vectors++;
        if (bus_obs(u) !== ((k == 1) ? MASK_WR : BUS_IDLE)) begin
          miscompares++;
          $display("FAIL mask_write u%0d k=%0d got=%h expected=%h", u, k, bus_obs(u),
                   (k == 1) ? MASK_WR : BUS_IDLE);
        end
      end
    end
    $display("reset release: mask write checked on both instances");
  endtask

  task automatic test_service(int u, int L, int iters);
    logic [2:0] m;
    logic [2:0] lvl;
    for (int it = 0; it < iters; it++) begin
      m = 3'($urandom_range(1, 7));
      press(u, m);
      lvl = pins[u];
      expect_service(u, L, 0, m, lvl);
      accept(u, $urandom_range(0, 3), m, lvl);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] m1;
    logic [2:0] l1;
    logic [2:0] l2;
    @(negedge clk);
    pins[0] = pins[0] & 3'b110;
    m1 = 3'($urandom_range(1, 3)) << 1;
    press(0, m1);
    l1 = pins[0];
    expect_service(0, 1, 0, m1, l1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if ({bus_obs(0), event_edges[0], event_level[0]} !== {1'b1, BUS_IDLE[35:0], m1, l1}) begin
        miscompares++;
        $display("FAIL stall_hold c=%0d got=%h expected=%h", c,
                 {bus_obs(0), event_edges[0], event_level[0]}, {1'b1, BUS_IDLE[35:0], m1, l1});
      end
      if (c == 5) pins[0][0] = 1'b1;
    end
    event_ready[0] = 1'b1;
    exp_count[0] = exp_count[0] + 16'd1;
    @(negedge clk);
    event_ready[0] = 1'b0;
    vectors++;
    if ({bus_obs(0), event_count[0]} !== {BUS_IDLE, exp_count[0]}) begin
      miscompares++;
      $display("FAIL stall_accept got=%h expected=%h", {bus_obs(0), event_count[0]}, {BUS_IDLE, exp_count[0]});
    end
    l2 = pins[0];
    expect_service(0, 1, 1, 3'b001, l2);
    accept(0, 1, 3'b001, l2);
  endtask

  task automatic test_spurious();
    logic [36:0] exp;
    @(negedge clk);
    spur[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      spur[0] = 1'b0;
      exp = (k <= 2) ? {1'b0, 1'b1, 1'b1, 2'd3, 32'h0} : BUS_IDLE;
      vectors++;
      if (bus_obs(0) !== exp) begin
        miscompares++;
        $display("FAIL spurious k=%0d got=%h expected=%h", k, bus_obs(0), exp);
      end
    end
    vectors++;
    if (event_count[0] !== exp_count[0]) begin
      miscompares++;
      $display("FAIL spurious_count got=%0d expected=%0d", event_count[0], exp_count[0]);
    end
    $display("spurious irq: count=%0d", event_count[0]);
  endtask

  task automatic test_reset_mid();
    press(0, 3'($urandom_range(1, 7)));
    for (int k = 0; k <= 3; k++) @(negedge clk);
    vectors++;
    if (bus_obs(0) !== svc_exp(3, 1)) begin
      miscompares++;
      $display("FAIL pre_reset_level_read got=%h expected=%h", bus_obs(0), svc_exp(3, 1));
    end
    reset_n = 1'b0;
    @(negedge clk);
    for (int u = 0; u < N; u++) begin
      exp_count[u] = '0;
      vectors++;
      if (rst_obs(u) !== RST_EXP) begin
        miscompares++;
        $display("FAIL mid_reset u%0d got=%h expected=%h", u, rst_obs(u), RST_EXP);
      end
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      vectors++;
      if (bus_obs(0) !== ((k == 1) ? MASK_WR : BUS_IDLE)) begin
        miscompares++;
        $display("FAIL mid_reset_rewrite k=%0d got=%h expected=%h", k, bus_obs(0),
                 (k == 1) ? MASK_WR : BUS_IDLE);
      end
    end
    $display("reset during RD_LEVEL: outputs cleared, mask rewritten");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    for (int u = 0; u < N; u++) begin
      pins[u]        = '0;
      spur[u]        = 1'b0;
      event_ready[u] = 1'b0;
      exp_count[u]   = '0;
    end
    test_reset();
    test_service(0, 1, 6);
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    test_service(0, 1, 2);
    test_service(1, 3, 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
